// File: rtl/avg_pkg.sv
// Shared types and constants for the moving-average filter controller.
// Holds the FSM encoding, engine mode codes and the warm-up length table.
package avg_pkg;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_FLUSH  = 2'd1;
   localparam logic [1:0] ST_WARMUP = 2'd2;
   localparam logic [1:0] ST_RUN    = 2'd3;

   localparam logic [2:0] MODE_NONE = 3'b000;
   localparam logic [2:0] MODE_X2   = 3'b001;
   localparam logic [2:0] MODE_X3   = 3'b010;
   localparam logic [2:0] MODE_X4   = 3'b011;
   localparam logic [2:0] MODE_X8   = 3'b100;
   localparam logic [2:0] MODE_X16  = 3'b101;

   typedef struct packed {
      logic [2:0] mode;
      logic       refresh;
   } cfg_t;

   // Number of samples the engine needs before its window is full.
   function automatic logic [4:0] warmup_len(input logic [2:0] mode);
      case (mode)
         MODE_NONE: warmup_len = 5'd1;
         MODE_X2:   warmup_len = 5'd2;
         MODE_X3:   warmup_len = 5'd3;
         MODE_X4:   warmup_len = 5'd4;
         MODE_X8:   warmup_len = 5'd8;
         MODE_X16:  warmup_len = 5'd16;
         default:   warmup_len = 5'd1;
      endcase
   endfunction

endpackage

// File: rtl/avg_filter_ctrl_if.sv
// Pin bundle between the controller (master) and one filter engine (slave).
interface avg_filter_ctrl_if #(
   parameter int DW = 16
) ();

   logic                 filt_rst_n;
   logic                 filt_enable;
   logic                 filt_data_refresh;
   logic [2:0]           filt_mode;
   logic                 filt_refresh_mode;
   logic signed [DW-1:0] filt_din;
   logic signed [DW-1:0] filt_dout;
   logic                 filt_output_pulse;

   modport master (
      output filt_rst_n, filt_enable, filt_data_refresh, filt_mode,
             filt_refresh_mode, filt_din,
      input  filt_dout, filt_output_pulse
   );

   modport slave (
      input  filt_rst_n, filt_enable, filt_data_refresh, filt_mode,
             filt_refresh_mode, filt_din,
      output filt_dout, filt_output_pulse
   );

endinterface

// File: rtl/avg_watchdog.sv
// Saturating silence counter: raises a sticky flag after TIMEOUT_CYCLES
// enabled cycles without a clear; the flag drops only on flag_clr or rst.
module avg_watchdog #(
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic clear,
   input  logic flag_clr,
   output logic flag
);

   localparam int             CW      = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CW-1:0]  LIMIT   = CW'(TIMEOUT_CYCLES);
   localparam logic [CW-1:0]  LIMIT_M1 = CW'(TIMEOUT_CYCLES - 1);

   logic [CW-1:0] cnt;

   // NOTE: registered state uses non-blocking assignments so every flop
   // samples the pre-edge value of its neighbours.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt  <= '0;
         flag <= 1'b0;
      end else begin
         if (clear || !en)
            cnt <= '0;
         else if (cnt != LIMIT)
            cnt <= cnt + 1'b1;

         if (flag_clr)
            flag <= 1'b0;
         else if (en && !clear && cnt == LIMIT_M1)
            flag <= 1'b1;
      end
   end

endmodule

// File: rtl/avg_filter_ctrl.sv
// Sequencer/configurator for one moving-average engine: flush on mode
// change, warm-up gating, sample forwarding and drop/stall reporting.
module avg_filter_ctrl
   import avg_pkg::*;
#(
   parameter int DW             = 16,
   parameter int FLUSH_CYCLES   = 4,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 run_en,
   input  logic                 cfg_valid,
   input  logic [2:0]           cfg_mode,
   input  logic                 cfg_refresh,
   input  logic                 adc_valid,
   input  logic signed [DW-1:0] adc_data,
   avg_filter_ctrl_if.master    eng,
   output logic                 avg_valid,
   output logic signed [DW-1:0] avg_data,
   output logic                 busy,
   output logic                 sample_drop,
   output logic                 stall
);

   localparam int              FCW        = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
   localparam logic [FCW-1:0]  FLUSH_LAST = FCW'(FLUSH_CYCLES - 1);

   logic [1:0]     state, state_nxt;
   cfg_t           shadow, cfg_in, cfg_nxt, live;
   logic [FCW-1:0] flush_cnt;
   logic [4:0]     warm_cnt;

   logic active, cfg_change, sample_ok, flush_done, warm_last;
   logic flush_entry, fwd;

   assign cfg_in  = '{mode: cfg_mode, refresh: cfg_refresh};
   assign live    = '{mode: eng.filt_mode, refresh: eng.filt_refresh_mode};
   assign cfg_nxt = cfg_valid ? cfg_in : shadow;

   assign active     = (state == ST_WARMUP) || (state == ST_RUN);
   assign cfg_change = cfg_valid && (cfg_in != live);
   // A mode-changing cfg in the same cycle wins over the sample.
   assign sample_ok  = run_en && active && adc_valid && !cfg_change;
   assign flush_done = (flush_cnt == FLUSH_LAST);
   assign warm_last  = sample_ok && (state == ST_WARMUP) &&
                       ((warm_cnt + 5'd1) == warmup_len(live.mode));

   // NOTE: the default assignment first keeps this block free of latches.
   always_comb begin
      state_nxt = state;
      if (!run_en) begin
         state_nxt = ST_IDLE;
      end else begin
         case (state)
            ST_IDLE:   state_nxt = ST_FLUSH;
            ST_FLUSH:  if (!cfg_valid && flush_done) state_nxt = ST_WARMUP;
            ST_WARMUP: begin
               if (cfg_change)     state_nxt = ST_FLUSH;
               else if (warm_last) state_nxt = ST_RUN;
            end
            ST_RUN:    if (cfg_change) state_nxt = ST_FLUSH;
            default:   state_nxt = ST_IDLE;
         endcase
      end
   end

   // cfg_valid during FLUSH re-enters it: count restarts, new cfg goes live.
   assign flush_entry = (state_nxt == ST_FLUSH) && ((state != ST_FLUSH) || cfg_valid);
   // Pulses are only trusted once the window is full and the mode is stable.
   assign fwd = eng.filt_output_pulse && (state == ST_RUN) && (state_nxt == ST_RUN);

   always_ff @(posedge clk) begin
      if (rst) begin
         state                 <= ST_IDLE;
         shadow                <= '0;
         flush_cnt             <= '0;
         warm_cnt              <= '0;
         eng.filt_rst_n        <= 1'b0;
         eng.filt_enable       <= 1'b0;
         eng.filt_data_refresh <= 1'b0;
         eng.filt_mode         <= MODE_NONE;
         eng.filt_refresh_mode <= 1'b0;
         eng.filt_din          <= '0;
         avg_valid             <= 1'b0;
         avg_data              <= '0;
         busy                  <= 1'b0;
         sample_drop           <= 1'b0;
      end else begin
         state <= state_nxt;
         if (cfg_valid)
            shadow <= cfg_in;

         eng.filt_rst_n  <= (state_nxt != ST_FLUSH);
         eng.filt_enable <= (state_nxt == ST_WARMUP) || (state_nxt == ST_RUN);
         busy            <= (state_nxt == ST_FLUSH) || (state_nxt == ST_WARMUP);

         if (flush_entry) begin
            flush_cnt             <= '0;
            eng.filt_mode         <= cfg_nxt.mode;
            eng.filt_refresh_mode <= cfg_nxt.refresh;
         end else if (state == ST_FLUSH && !flush_done) begin
            flush_cnt <= flush_cnt + 1'b1;
         end

         if (state_nxt != ST_WARMUP)
            warm_cnt <= '0;
         else if (sample_ok)
            warm_cnt <= warm_cnt + 5'd1;

         eng.filt_data_refresh <= sample_ok;
         if (sample_ok)
            eng.filt_din <= adc_data;
         sample_drop <= adc_valid && !sample_ok;

         avg_valid <= fwd;
         if (fwd)
            avg_data <= eng.filt_dout;
      end
   end

   avg_watchdog #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_watchdog (
      .clk      (clk),
      .rst      (rst),
      .en       (run_en && active),
      .clear    (adc_valid),
      .flag_clr (cfg_valid),
      .flag     (stall)
   );

endmodule

// File: tb/tb_avg_filter_ctrl.sv
// Directed bench for avg_filter_ctrl with a behavioural averaging engine.
module tb_avg_filter_ctrl;

   localparam int DW = 16;

   logic                 clk = 1'b0;
   logic                 rst, run_en, cfg_valid, cfg_refresh, adc_valid;
   logic [2:0]           cfg_mode;
   logic signed [DW-1:0] adc_data;
   logic                 avg_valid, busy, sample_drop, stall;
   logic signed [DW-1:0] avg_data;

   int n_checks = 0;
   int n_fail   = 0;

   avg_filter_ctrl_if #(.DW(DW)) eng_bus ();

   avg_filter_ctrl #(
      .DW(DW), .FLUSH_CYCLES(4), .TIMEOUT_CYCLES(16)
   ) dut (
      .clk(clk), .rst(rst), .run_en(run_en), .cfg_valid(cfg_valid),
      .cfg_mode(cfg_mode), .cfg_refresh(cfg_refresh), .adc_valid(adc_valid),
      .adc_data(adc_data), .eng(eng_bus), .avg_valid(avg_valid),
      .avg_data(avg_data), .busy(busy), .sample_drop(sample_drop), .stall(stall)
   );

   always #5 clk = ~clk;

   // Engine: averages the last N samples, pulses per sample or per window.
   logic signed [DW-1:0] hist [16];
   int ecnt;

   function automatic int eng_len(input logic [2:0] m);
      case (m)
         3'd1: return 2;
         3'd2: return 3;
         3'd3: return 4;
         3'd4: return 8;
         3'd5: return 16;
         default: return 1;
      endcase
   endfunction

   function automatic int win_avg(input logic signed [DW-1:0] din, input logic [2:0] m);
      int n = eng_len(m);
      int sum = int'(din);
      for (int i = 0; i < n - 1; i++) sum += int'(hist[i]);
      return sum / n;
   endfunction

   always @(posedge clk) begin
      if (eng_bus.filt_rst_n !== 1'b1) begin
         for (int i = 0; i < 16; i++) hist[i] <= '0;
         ecnt                      <= 0;
         eng_bus.filt_output_pulse <= 1'b0;
         eng_bus.filt_dout         <= '0;
      end else begin
         eng_bus.filt_output_pulse <= 1'b0;
         if (eng_bus.filt_enable && eng_bus.filt_data_refresh) begin
            for (int i = 15; i > 0; i--) hist[i] <= hist[i-1];
            hist[0]                   <= eng_bus.filt_din;
            ecnt                      <= ecnt + 1;
            eng_bus.filt_dout         <= DW'(win_avg(eng_bus.filt_din, eng_bus.filt_mode));
            eng_bus.filt_output_pulse <= eng_bus.filt_refresh_mode ||
                                         (((ecnt + 1) % eng_len(eng_bus.filt_mode)) == 0);
         end
      end
   end

   task automatic check(input string tag, input logic signed [31:0] got,
                        input logic signed [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic send_cfg(input logic [2:0] m, input logic r);
      cfg_valid = 1'b1; cfg_mode = m; cfg_refresh = r;
      tick();
      cfg_valid = 1'b0;
   endtask

   // Counts flush-low cycles from the current negedge until enable rises.
   task automatic wait_enable(input string tag, output int low);
      bit seen = 1'b0;
      low = 0;
      for (int i = 0; i < 32; i++) begin
         if (!eng_bus.filt_rst_n) low++;
         if (eng_bus.filt_enable) begin
            seen = 1'b1;
            break;
         end
         tick();
      end
      if (!seen) check({tag, " enable timeout"}, 0, 1);
   endtask

   // Drives one sample and watches 4 cycles; a forwarded average must land
   // exactly on the third cycle after the strobe.
   task automatic sample(input string tag, input int v, input bit exp_out, input int exp_avg);
      logic [3:0] pat = '0;
      logic signed [DW-1:0] got = '0;
      adc_valid = 1'b1; adc_data = DW'(v);
      tick();
      adc_valid = 1'b0;
      check({tag, " refresh"}, eng_bus.filt_data_refresh, 1);
      check({tag, " din"}, eng_bus.filt_din, v);
      for (int k = 1; k <= 4; k++) begin
         if (k > 1) tick();
         pat[k-1] = avg_valid;
         if (avg_valid) got = avg_data;
      end
      check({tag, " valid pattern"}, pat, exp_out ? 4'b0100 : 4'b0000);
      if (exp_out) check({tag, " avg"}, got, exp_avg);
   endtask

   initial begin
      #300000;
      $display("FAIL global timeout");
      $fatal(1, "global timeout");
   end

   initial begin
      int low;
      rst = 1'b1; run_en = 1'b0; cfg_valid = 1'b0; cfg_mode = '0;
      cfg_refresh = 1'b0; adc_valid = 1'b0; adc_data = '0;
      repeat (3) tick();
      check("rst filt_rst_n", eng_bus.filt_rst_n, 0);
      check("rst enable", eng_bus.filt_enable, 0);
      check("rst refresh", eng_bus.filt_data_refresh, 0);
      check("rst mode", eng_bus.filt_mode, 0);
      check("rst refresh_mode", eng_bus.filt_refresh_mode, 0);
      check("rst din", eng_bus.filt_din, 0);
      check("rst avg", {avg_valid, busy, sample_drop, stall}, 0);
      check("rst avg_data", avg_data, 0);

      rst = 1'b0;
      tick();
      check("idle filt_rst_n", eng_bus.filt_rst_n, 1);
      send_cfg(3'b011, 1'b1);
      check("idle mode not live", eng_bus.filt_mode, 0);

      // Flush on start-up, then warm-up with mode x4
      run_en = 1'b1;
      tick();
      check("flush busy", busy, 1);
      wait_enable("start", low);
      check("start flush cycles", low, 4);
      check("start busy", busy, 1);
      check("start mode", eng_bus.filt_mode, 3);
      check("start refresh_mode", eng_bus.filt_refresh_mode, 1);

      sample("x4 s1", 100, 0, 0);
      sample("x4 s2", 200, 0, 0);
      sample("x4 s3", 300, 0, 0);
      sample("x4 s4", 400, 1, 250);
      check("x4 run busy", busy, 0);
      sample("x4 s5", 500, 1, 350);
      sample("x4 s6", 600, 1, 450);

      // Mode x2, then switch to x16
      send_cfg(3'b001, 1'b1);
      wait_enable("x2", low);
      check("x2 flush cycles", low, 4);
      sample("x2 s1", 1000, 0, 0);
      sample("x2 s2", 2000, 1, 1500);
      send_cfg(3'b101, 1'b1);
      check("x16 busy", busy, 1);
      check("x16 mode", eng_bus.filt_mode, 5);
      wait_enable("x16", low);
      check("x16 flush cycles", low, 4);
      for (int i = 1; i <= 15; i++) sample("x16 warm", 10 * i, 0, 0);
      sample("x16 s16", 160, 1, 85);

      // Identical cfg: no flush
      send_cfg(3'b101, 1'b1);
      check("same cfg busy", busy, 0);
      check("same cfg filt_rst_n", eng_bus.filt_rst_n, 1);
      check("same cfg enable", eng_bus.filt_enable, 1);
      sample("same cfg s", 170, 1, 95);

      // Mode-changing cfg with a sample in the same cycle, then a FLUSH sample
      cfg_valid = 1'b1; cfg_mode = 3'b011; cfg_refresh = 1'b1;
      adc_valid = 1'b1; adc_data = 16'sd777;
      tick();
      cfg_valid = 1'b0;
      check("coll drop", sample_drop, 1);
      check("coll refresh", eng_bus.filt_data_refresh, 0);
      check("coll busy", busy, 1);
      check("coll mode", eng_bus.filt_mode, 3);
      check("coll din held", eng_bus.filt_din, 170);
      adc_data = 16'sd888;
      tick();
      adc_valid = 1'b0;
      check("flush drop", sample_drop, 1);
      check("flush refresh", eng_bus.filt_data_refresh, 0);
      tick();
      check("flush drop clear", sample_drop, 0);
      wait_enable("recover", low);

      // Watchdog
      sample("wd s1", 1, 0, 0);
      sample("wd s2", 2, 0, 0);
      sample("wd s3", 3, 0, 0);
      sample("wd s4", 4, 1, 2);
      adc_valid = 1'b1; adc_data = 16'sd5;
      tick();
      adc_valid = 1'b0;
      send_cfg(3'b011, 1'b1);
      check("wd cleared", stall, 0);
      repeat (14) tick();
      check("wd 15 silent", stall, 0);
      tick();
      check("wd 16 silent", stall, 1);
      adc_valid = 1'b1; adc_data = 16'sd6;
      tick();
      adc_valid = 1'b0;
      check("wd sticky", stall, 1);
      tick();
      check("wd sticky 2", stall, 1);
      send_cfg(3'b011, 1'b1);
      check("wd cfg clear", stall, 0);
      check("wd no flush", busy, 0);

      // run_en low wins over a sample
      run_en = 1'b0; adc_valid = 1'b1; adc_data = 16'sd9;
      tick();
      adc_valid = 1'b0;
      check("stop enable", eng_bus.filt_enable, 0);
      check("stop filt_rst_n", eng_bus.filt_rst_n, 1);
      check("stop busy", busy, 0);
      check("stop drop", sample_drop, 1);
      check("stop refresh", eng_bus.filt_data_refresh, 0);
      repeat (3) tick();
      check("stop avg_valid", avg_valid, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
